// File: rtl/pulse_acq_sequencer.sv
// pulse_acq_sequencer: user-interface sequencer for the HeartAware pulse pipeline.
// Steps IDLE -> ACQUIRE -> ANALYZE -> DISPLAY, driving sample-buffer writes, the
// BPM calculation start and the display refresh from synchronized start/stop levels.
//
// Ports:
//   clock_25mhz    in   system clock
//   system_reset   in   synchronous active-high reset
//   start_sw       in   start level (acted on at rising edge)
//   stop_sw        in   stop level (acted on at rising edge, highest priority)
//   sample_strobe  in   one-cycle pulse, new ADC sample valid
//   buf_wr_en      out  sample buffer write enable
//   buf_wr_addr    out  sample buffer write address
//   calc_start     out  one-cycle pulse, begin BPM calculation
//   calc_done      in   one-cycle pulse, bpm_in valid
//   bpm_in         in   BPM result from calculation unit
//   bpm            out  latched BPM for display
//   bpm_valid      out  bpm holds a result from the current run
//   disp_update    out  one-cycle pulse, display refresh
//   timeout_err    out  sticky, last ANALYZE timed out
//   state          out  IDLE=0, ACQUIRE=1, ANALYZE=2, DISPLAY=3
//
// Optional feature: define BPM_AVERAGE_EN to report the mean of the last four results.
module pulse_acq_sequencer #(
  parameter int unsigned SAMPLE_COUNT = 1024,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned CALC_TIMEOUT = 2500000,
  parameter int unsigned DISPLAY_HOLD = 25000000
) (
  input  logic              clock_25mhz,
  input  logic              system_reset,
  input  logic              start_sw,
  input  logic              stop_sw,
  input  logic              sample_strobe,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              calc_start,
  input  logic              calc_done,
  input  logic [7:0]        bpm_in,
  output logic [7:0]        bpm,
  output logic              bpm_valid,
  output logic              disp_update,
  output logic              timeout_err,
  output logic [1:0]        state
);

  localparam int unsigned CNT_MAX = (CALC_TIMEOUT > DISPLAY_HOLD) ? CALC_TIMEOUT : DISPLAY_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    ANALYZE = 2'd2,
    DISPLAY = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              start_prev, stop_prev;
  logic              start_edge, stop_edge;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_en_d, calc_start_d, disp_update_d, bpm_valid_d, timeout_err_d;
  logic [7:0]        bpm_d;

`ifdef BPM_AVERAGE_EN
  logic [3:0][7:0]   hist_q, hist_d;
  logic              hist_fill_q, hist_fill_d;
  logic [9:0]        hist_sum;
`endif

  assign start_edge = start_sw & ~start_prev;
  assign stop_edge  = stop_sw & ~stop_prev;
  assign state      = state_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    addr_d        = buf_wr_addr;
    wr_en_d       = 1'b0;
    calc_start_d  = 1'b0;
    disp_update_d = 1'b0;
    bpm_d         = bpm;
    bpm_valid_d   = bpm_valid;
    timeout_err_d = timeout_err;
`ifdef BPM_AVERAGE_EN
    hist_d        = hist_q;
    hist_fill_d   = hist_fill_q;
    hist_sum      = '0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge && !stop_edge) begin
          state_d       = ACQUIRE;
          addr_d        = '0;
          bpm_valid_d   = 1'b0;
          timeout_err_d = 1'b0;
`ifdef BPM_AVERAGE_EN
          hist_d        = '0;
          hist_fill_d   = 1'b1;
`endif
        end
      end

      ACQUIRE: begin
        cnt_d = '0;
        if (stop_edge) begin
          state_d = IDLE;
        end else if (buf_wr_en && buf_wr_addr == ADDR_W'(SAMPLE_COUNT - 1)) begin
          state_d      = ANALYZE;
          calc_start_d = 1'b1;
          addr_d       = '0;
        end else begin
          // Address advances the cycle after each write; a strobe landing on
          // that cycle is dropped so buf_wr_en never stays high two cycles.
          if (buf_wr_en) addr_d = buf_wr_addr + ADDR_W'(1);
          else if (sample_strobe) wr_en_d = 1'b1;
        end
      end

      ANALYZE: begin
        if (stop_edge) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (calc_done) begin
          state_d       = DISPLAY;
          cnt_d         = '0;
          bpm_valid_d   = 1'b1;
          disp_update_d = 1'b1;
`ifdef BPM_AVERAGE_EN
          // First result of a run seeds the whole history
          if (hist_fill_q) hist_d = {4{bpm_in}};
          else             hist_d = {hist_q[2:0], bpm_in};
          hist_fill_d = 1'b0;
          hist_sum    = 10'(hist_d[0]) + 10'(hist_d[1]) + 10'(hist_d[2]) + 10'(hist_d[3]);
          bpm_d       = hist_sum[9:2];
`else
          bpm_d         = bpm_in;
`endif
        end else if (cnt_q == CNT_W'(CALC_TIMEOUT - 1)) begin
          state_d       = IDLE;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end
      end

      DISPLAY: begin
        if (stop_edge) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DISPLAY_HOLD - 1)) begin
          state_d = ACQUIRE;
          cnt_d   = '0;
          addr_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clock_25mhz) begin
    if (system_reset) begin
      state_q     <= IDLE;
      start_prev  <= 1'b1;
      stop_prev   <= 1'b1;
      cnt_q       <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      calc_start  <= 1'b0;
      disp_update <= 1'b0;
      bpm         <= '0;
      bpm_valid   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef BPM_AVERAGE_EN
      hist_q      <= '0;
      hist_fill_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      start_prev  <= start_sw;
      stop_prev   <= stop_sw;
      cnt_q       <= cnt_d;
      buf_wr_en   <= wr_en_d;
      buf_wr_addr <= addr_d;
      calc_start  <= calc_start_d;
      disp_update <= disp_update_d;
      bpm         <= bpm_d;
      bpm_valid   <= bpm_valid_d;
      timeout_err <= timeout_err_d;
`ifdef BPM_AVERAGE_EN
      hist_q      <= hist_d;
      hist_fill_q <= hist_fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_pulse_acq_sequencer.sv
// Self-checking bench for pulse_acq_sequencer (SAMPLE_COUNT=8, ADDR_W=3,
// CALC_TIMEOUT=20, DISPLAY_HOLD=10).
module tb_pulse_acq_sequencer;

  localparam int unsigned SAMPLE_COUNT = 8;
  localparam int unsigned ADDR_W       = 3;
  localparam int unsigned CALC_TIMEOUT = 20;
  localparam int unsigned DISPLAY_HOLD = 10;

  logic              clk;
  logic              system_reset;
  logic              start_sw, stop_sw, sample_strobe, calc_done;
  logic [7:0]        bpm_in;
  logic              buf_wr_en, calc_start, bpm_valid, disp_update, timeout_err;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [7:0]        bpm;
  logic [1:0]        state;

  int total = 0;
  int bad   = 0;
  int exp_wr_q[$];
  int calc_start_seen = 0;
  int calc_start_exp  = 0;
  logic prev_wr = 1'b0, prev_cs = 1'b0, prev_du = 1'b0;

  pulse_acq_sequencer #(
    .SAMPLE_COUNT(SAMPLE_COUNT),
    .ADDR_W      (ADDR_W),
    .CALC_TIMEOUT(CALC_TIMEOUT),
    .DISPLAY_HOLD(DISPLAY_HOLD)
  ) dut (
    .clock_25mhz  (clk),
    .system_reset (system_reset),
    .start_sw     (start_sw),
    .stop_sw      (stop_sw),
    .sample_strobe(sample_strobe),
    .buf_wr_en    (buf_wr_en),
    .buf_wr_addr  (buf_wr_addr),
    .calc_start   (calc_start),
    .calc_done    (calc_done),
    .bpm_in       (bpm_in),
    .bpm          (bpm),
    .bpm_valid    (bpm_valid),
    .disp_update  (disp_update),
    .timeout_err  (timeout_err),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write scoreboard and single-cycle pulse checks, sampled mid-cycle
  always @(negedge clk) begin
    if (buf_wr_en) begin
      check("wr_in_acquire", int'(state), 1);
      if (exp_wr_q.size() == 0) check("unexpected_write", int'(buf_wr_addr), -1);
      else check("wr_addr", int'(buf_wr_addr), exp_wr_q.pop_front());
      check("wr_en_single", int'(prev_wr), 0);
    end
    if (calc_start) begin
      calc_start_seen++;
      check("calc_start_single", int'(prev_cs), 0);
    end
    if (disp_update) check("disp_update_single", int'(prev_du), 0);
    prev_wr = buf_wr_en;
    prev_cs = calc_start;
    prev_du = disp_update;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_addr"}, int'(buf_wr_addr), 0);
    check({tag, "_wr_en"}, int'(buf_wr_en), 0);
    check({tag, "_calc_start"}, int'(calc_start), 0);
    check({tag, "_disp_update"}, int'(disp_update), 0);
    check({tag, "_bpm"}, int'(bpm), 0);
    check({tag, "_bpm_valid"}, int'(bpm_valid), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  // Stop, release, then start edge: ends in ACQUIRE
  task automatic restart();
    stop_sw = 1'b1; tick();
    check("restart_stop_state", int'(state), 0);
    stop_sw = 1'b0; start_sw = 1'b0; tick();
    start_sw = 1'b1; tick();
    check("restart_state", int'(state), 1);
    check("restart_addr", int'(buf_wr_addr), 0);
    check("restart_bpm_valid", int'(bpm_valid), 0);
    check("restart_timeout_err", int'(timeout_err), 0);
    start_sw = 1'b0;
  endtask

  // Full window of strobes; ends in first ANALYZE cycle
  task automatic acquire_window();
    for (int i = 0; i < int'(SAMPLE_COUNT); i++) begin
      sample_strobe = 1'b1;
      exp_wr_q.push_back(i);
      tick();
      sample_strobe = 1'b0;
      tick();
      if (i < int'(SAMPLE_COUNT) - 1) check("acq_addr_next", int'(buf_wr_addr), i + 1);
    end
    calc_start_exp++;
    check("analyze_entry_state", int'(state), 2);
    check("analyze_calc_start", int'(calc_start), 1);
  endtask

  typedef struct {
    logic [7:0] bpm_value;
    int         done_delay;
    bit         do_restart;
    int         exp_raw;
    int         exp_avg;
  } run_vec_t;

  run_vec_t runs[5];
  int       exp_bpm;

  initial begin
    runs[0] = '{8'd72,  5, 1'b1, 72,  72};
    runs[1] = '{8'd60,  3, 1'b1, 60,  60};
    runs[2] = '{8'd80,  5, 1'b0, 80,  65};
    runs[3] = '{8'd80,  1, 1'b0, 80,  70};
    runs[4] = '{8'd100, 7, 1'b0, 100, 80};

    system_reset = 1'b1;
    start_sw = 1'b0; stop_sw = 1'b0; sample_strobe = 1'b0;
    calc_done = 1'b0; bpm_in = 8'd0;
    tick(); tick();
    check_reset_outputs("por");
    system_reset = 1'b0;
    tick();

    exp_bpm = 0;
    for (int r = 0; r < 5; r++) begin
      if (runs[r].do_restart) restart();
      acquire_window();
      check("analyze_addr_wrap", int'(buf_wr_addr), 0);
      repeat (runs[r].done_delay) tick();
      check("analyze_wait_state", int'(state), 2);
      calc_done = 1'b1; bpm_in = runs[r].bpm_value;
      tick();
      calc_done = 1'b0; bpm_in = 8'd0;
`ifdef BPM_AVERAGE_EN
      exp_bpm = runs[r].exp_avg;
`else
      exp_bpm = runs[r].exp_raw;
`endif
      check("done_state", int'(state), 3);
      check("done_bpm", int'(bpm), exp_bpm);
      check("done_bpm_valid", int'(bpm_valid), 1);
      check("done_disp_update", int'(disp_update), 1);
      repeat (DISPLAY_HOLD - 1) tick();
      check("display_last_cycle", int'(state), 3);
      check("display_disp_low", int'(disp_update), 0);
      tick();
      check("reacq_state", int'(state), 1);
      check("reacq_addr", int'(buf_wr_addr), 0);
      check("reacq_bpm", int'(bpm), exp_bpm);
      check("reacq_bpm_valid", int'(bpm_valid), 1);
    end

    // Timeout: no calc_done for the whole ANALYZE budget
    acquire_window();
    repeat (CALC_TIMEOUT - 1) tick();
    check("timeout_last_analyze", int'(state), 2);
    calc_done = 1'b0;
    tick();
    check("timeout_state", int'(state), 0);
    check("timeout_err_set", int'(timeout_err), 1);
    check("timeout_bpm_kept", int'(bpm), exp_bpm);
    check("timeout_valid_kept", int'(bpm_valid), 1);
    tick();
    check("calc_done_ignored_idle", int'(state), 0);
    start_sw = 1'b1; tick();
    check("timeout_restart_state", int'(state), 1);
    check("timeout_err_cleared", int'(timeout_err), 0);
    start_sw = 1'b0;

    // Stop coincident with the final strobe: write and calc_start suppressed
    for (int i = 0; i < int'(SAMPLE_COUNT) - 1; i++) begin
      sample_strobe = 1'b1;
      exp_wr_q.push_back(i);
      tick();
      sample_strobe = 1'b0;
      tick();
    end
    check("stop_pre_addr", int'(buf_wr_addr), int'(SAMPLE_COUNT) - 1);
    sample_strobe = 1'b1; stop_sw = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("stop_state", int'(state), 0);
    check("stop_no_write", int'(buf_wr_en), 0);
    tick();
    check("stop_no_calc_start", int'(calc_start), 0);
    check("stop_still_idle", int'(state), 0);

    // Stop and start together from IDLE
    stop_sw = 1'b0; start_sw = 1'b0; tick();
    stop_sw = 1'b1; start_sw = 1'b1; tick();
    check("stop_start_idle", int'(state), 0);
    tick();
    check("stop_start_idle_hold", int'(state), 0);
    stop_sw = 1'b0; start_sw = 1'b0; tick();

    // Reset in the middle of ANALYZE
    start_sw = 1'b1; tick();
    check("pre_reset_acquire", int'(state), 1);
    start_sw = 1'b0;
    acquire_window();
    tick(); tick();
    system_reset = 1'b1;
    tick();
    check_reset_outputs("mid_reset");

    // Start held high through reset must not start a run
    start_sw = 1'b1;
    tick();
    system_reset = 1'b0;
    tick(); tick(); tick();
    check("held_start_idle", int'(state), 0);
    start_sw = 1'b0; tick();
    check("held_release_idle", int'(state), 0);
    start_sw = 1'b1; tick();
    check("held_reassert_acquire", int'(state), 1);
    start_sw = 1'b0;
    stop_sw = 1'b1; tick();
    check("final_stop", int'(state), 0);
    stop_sw = 1'b0;
    tick();

    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("calc_start_count", calc_start_seen, calc_start_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_acq_sequencer.md
Name: pulse_acq_sequencer

Overview:
- Four-state user-interface controller (IDLE, ACQUIRE, ANALYZE, DISPLAY) for the HeartAware pulse pipeline.
- Runs on the 25 MHz system clock. Takes synchronized start/stop controls and sequences the sample buffer writes, the BPM calculation unit and the display refresh.
- Sits between the switch/button synchronizers and the acquisition/analysis/display datapaths.

Parameters:
- SAMPLE_COUNT, 1024: samples captured per acquisition window.
- ADDR_W, 10: buffer address width; SAMPLE_COUNT must be ≤ 2^ADDR_W.
- CALC_TIMEOUT, 2500000: cycles allowed in ANALYZE before abort (100 ms at 25 MHz).
- DISPLAY_HOLD, 25000000: cycles spent in DISPLAY before re-acquiring (1 s).

Ports:
- clock_25mhz  in  1  system clock.
- system_reset  in  1  synchronous, active-high reset.
- start_sw  in  1  synchronized start control, level; acted on at rising edge.
- stop_sw  in  1  synchronized stop control, level; acted on at rising edge.
- sample_strobe  in  1  one-cycle pulse: new ADC sample valid.
- buf_wr_en  out  1  sample buffer write enable.
- buf_wr_addr  out  ADDR_W  sample buffer write address.
- calc_start  out  1  one-cycle pulse: begin BPM calculation.
- calc_done  in  1  one-cycle pulse: BPM result valid on bpm_in.
- bpm_in  in  8  BPM result from calculation unit.
- bpm  out  8  latched BPM for display.
- bpm_valid  out  1  bpm holds a result from the current run.
- disp_update  out  1  one-cycle pulse: display must refresh.
- timeout_err  out  1  sticky: last ANALYZE timed out.
- state  out  2  IDLE=0, ACQUIRE=1, ANALYZE=2, DISPLAY=3.

Behaviour:
- Reset values:
  - state IDLE; buf_wr_addr 0.
  - buf_wr_en, calc_start, disp_update, bpm_valid, timeout_err all 0; bpm 0.
  - Edge-detect history registers reset to 1, so a control held through reset produces no edge.
  - All counters 0.
- Edge detection: start_edge = start_sw & ~prev; same for stop. Reset mid-operation returns to IDLE on the next edge regardless of state.
- All outputs are registered. Decisions are made on cycle N; outputs and state change at edge N+1.
- IDLE:
  - start_edge → ACQUIRE.
  - On entry to ACQUIRE: buf_wr_addr=0, bpm_valid=0, timeout_err=0.
- ACQUIRE:
  - On sample_strobe: buf_wr_en=1 for one cycle with the current buf_wr_addr, then the address increments.
  - The write at address SAMPLE_COUNT-1 → ANALYZE. calc_start pulses during the first ANALYZE cycle, one cycle after that write. The address wraps to 0 (no write beyond SAMPLE_COUNT-1).
  - sample_strobe is ignored in every other state; buf_wr_en stays 0 outside ACQUIRE.
- ANALYZE:
  - Cycle counter starts at 0 on entry.
  - calc_done → latch bpm_in into bpm, set bpm_valid=1, pulse disp_update, go to DISPLAY.
  - Counter reaches CALC_TIMEOUT-1 without calc_done → IDLE with timeout_err=1; bpm and bpm_valid unchanged.
  - calc_done and timeout in the same cycle: done wins.
  - calc_done is ignored outside ANALYZE.
- DISPLAY:
  - Hold counter runs for DISPLAY_HOLD cycles, then → ACQUIRE with buf_wr_addr=0.
  - bpm and bpm_valid are held through the transition and update only at the next calc_done.
- Priority:
  - stop_edge in any non-IDLE state → IDLE next cycle. It overrides sample completion, calc_done and timeout.
  - A sample write in the same cycle as stop_edge is suppressed.
  - stop_edge + start_edge in the same cycle: stop wins. From IDLE, neither causes a transition.
  - start_edge outside IDLE is ignored.
- No pulse output (calc_start, disp_update, buf_wr_en) is ever high for two consecutive cycles.

Optional Feature:
- Macro: BPM_AVERAGE_EN.
- Defined:
  - bpm outputs the mean of the last 4 calc_done results: a 4-entry 8-bit history with a 10-bit sum, right-shifted by 2 and truncated.
  - The first result after IDLE→ACQUIRE fills all 4 entries.
  - The history is cleared on IDLE→ACQUIRE.
  - Same latency as the undefined case: bpm valid together with disp_update.
- Undefined: bpm is the raw bpm_in latched at calc_done.

Test Plan (bench parameters SAMPLE_COUNT=8, ADDR_W=3, CALC_TIMEOUT=20, DISPLAY_HOLD=10):
- Nominal run:
  - Stimulus: start edge; 8 sample_strobes; calc_done with bpm_in=72 five cycles after calc_start.
  - Response: writes at addresses 0..7; calc_start exactly once, one cycle after the address-7 write; bpm=72, bpm_valid=1 and disp_update pulse in the same cycle; state 3.
- Auto re-acquire:
  - Stimulus: remain in DISPLAY for 10 cycles.
  - Response: state 1, buf_wr_addr=0, bpm still 72.
- Timeout:
  - Stimulus: no calc_done for 20 cycles in ANALYZE.
  - Response: state 0, timeout_err=1.
  - Then a start edge clears timeout_err.
- Stop priority:
  - Stimulus: stop edge coincident with the 8th sample_strobe.
  - Response: no write, no calc_start, state 0.
  - Stop+start in the same cycle from IDLE: stays IDLE.
- Reset and held controls:
  - Stimulus: start_sw held high across system_reset.
  - Response: stays IDLE until start_sw is released and re-asserted.
  - Stimulus: system_reset during ANALYZE.
  - Response: all outputs at reset values next cycle.
- BPM_AVERAGE_EN:
  - Stimulus: results 60, 80, 80, 100 across 4 loops.
  - Response: bpm=60, 65, 70, 80.
